// File: rtl/mulpp_pkg.sv
// Shared definitions for the mulpp multiply-accumulate pipeline.
// The operand-width defaults are the same ones the divpp divider uses.
package mulpp_pkg;

  localparam int DM_WIDTH = 8;
  localparam int DM_RW    = 2 * DM_WIDTH;

  typedef struct packed {
    logic valid;
    logic rem_err;
  } mulpp_flags_t;

endpackage

// File: rtl/mulpp_if.sv
// Operand/result bundle for mulpp: advance enable, operand set in, result set out.
interface mulpp_if
  import mulpp_pkg::*;
#(
  parameter int WIDTH = DM_WIDTH
);

  logic               en;
  logic               in_valid;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   rem;
  logic               out_valid;
  logic [2*WIDTH-1:0] num;
  logic               ovf;
  logic               rem_err;

  modport master (
    output en, in_valid, quo, den, rem,
    input  out_valid, num, ovf, rem_err
  );

  modport slave (
    input  en, in_valid, quo, den, rem,
    output out_valid, num, ovf, rem_err
  );

endinterface

// File: rtl/mulpp_stage.sv
// One shift-add step of mulpp: adds den<<STAGE_IDX to the running sum when quo[STAGE_IDX] is set.
module mulpp_stage
  import mulpp_pkg::*;
#(
  parameter int WIDTH     = DM_WIDTH,
  parameter int STAGE_IDX = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  mulpp_flags_t       flags_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   den_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output mulpp_flags_t       flags_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   den_o,
  output logic [2*WIDTH-1:0] acc_o
);

  localparam int RW = 2 * WIDTH;

  mulpp_flags_t     flags_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    addend;
  logic [RW-1:0]    acc_d;

  always_comb begin
    addend = '0;
    if (quo_i[STAGE_IDX]) begin
      addend = {{WIDTH{1'b0}}, den_i} << STAGE_IDX;
    end
    acc_d = acc_i + addend;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      acc_q   <= '0;
    end else if (en) begin
      flags_q <= flags_i;
      quo_q   <= quo_i;
      den_q   <= den_i;
      acc_q   <= acc_d;
    end
  end

  assign flags_o = flags_q;
  assign quo_o   = quo_q;
  assign den_o   = den_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/mulpp.sv
// Pipelined shift-add multiply-accumulate: num = quo*den + rem, WIDTH cycles of latency.
// Rebuilds a divpp dividend from its quotient/remainder and flags illegal operand sets.
module mulpp
  import mulpp_pkg::*;
#(
  parameter int WIDTH = DM_WIDTH
) (
  input  logic   clk,
  input  logic   reset,
  mulpp_if.slave bus
);

  localparam int RW = 2 * WIDTH;

  // Index 0 is the input register; index k+1 is the output of shift-add stage k.
  mulpp_flags_t [WIDTH:0]            flags_s;
  logic         [WIDTH:0][WIDTH-1:0] quo_s;
  logic         [WIDTH:0][WIDTH-1:0] den_s;
  logic         [WIDTH:0][RW-1:0]    acc_s;

  mulpp_flags_t     flags_d;
  logic [RW-1:0]    acc_d;
  mulpp_flags_t     flags_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;
  logic [RW-1:0]    acc_q;
  logic             unused_tail;

  always_comb begin
    flags_d.valid   = bus.in_valid;
    flags_d.rem_err = (bus.den == '0) || (bus.rem >= bus.den);
    acc_d           = {{WIDTH{1'b0}}, bus.rem};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      acc_q   <= '0;
    end else if (bus.en) begin
      flags_q <= flags_d;
      quo_q   <= bus.quo;
      den_q   <= bus.den;
      acc_q   <= acc_d;
    end
  end

  assign flags_s[0] = flags_q;
  assign quo_s[0]   = quo_q;
  assign den_s[0]   = den_q;
  assign acc_s[0]   = acc_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      mulpp_stage #(
        .WIDTH     (WIDTH),
        .STAGE_IDX (gi)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.en),
        .flags_i (flags_s[gi]),
        .quo_i   (quo_s[gi]),
        .den_i   (den_s[gi]),
        .acc_i   (acc_s[gi]),
        .flags_o (flags_s[gi+1]),
        .quo_o   (quo_s[gi+1]),
        .den_o   (den_s[gi+1]),
        .acc_o   (acc_s[gi+1])
      );
    end
  endgenerate

  // The operands have no consumer once the last stage has used them.
  assign unused_tail = ^{quo_s[WIDTH], den_s[WIDTH]};

  always_comb begin
    bus.out_valid = flags_s[WIDTH].valid;
    bus.num       = '0;
    bus.ovf       = 1'b0;
    bus.rem_err   = 1'b0;
    if (flags_s[WIDTH].valid) begin
      bus.num     = acc_s[WIDTH];
      bus.ovf     = |acc_s[WIDTH][RW-1:WIDTH];
      bus.rem_err = flags_s[WIDTH].rem_err;
    end
  end

endmodule

// File: tb/tb_mulpp.sv
// Self-checking bench for mulpp: fixed vector table, bubble/stall/reset sequences,
// and a randomized run against an in-order scoreboard of arithmetic expectations.
module tb_mulpp;
  import mulpp_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W-1:0] r;
    int unsigned  num;
    logic         ovf;
    logic         err;
  } vec_t;

  typedef struct {
    int unsigned num;
    logic        ovf;
    logic        err;
    int unsigned due;
  } exp_t;

  logic clk;
  logic reset;

  mulpp_if #(.WIDTH(W)) bus ();

  mulpp #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          npass = 0;
  int          ntotal = 0;
  int unsigned cyc = 0;
  int unsigned ecnt = 0;
  exp_t        sb [$];
  vec_t        tbl [7];

  logic          s_ov, s_ovf, s_err;
  logic [2*W-1:0] s_num;
  logic          p_ov, p_ovf, p_err;
  logic [2*W-1:0] p_num;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive inputs, update the scoreboard at the edge, then sample and check.
  task automatic cycle(input logic rst_v, input logic en_v, input logic iv_v,
                       input logic [W-1:0] q_v, input logic [W-1:0] d_v, input logic [W-1:0] r_v);
    exp_t e;
    reset        = rst_v;
    bus.en       = en_v;
    bus.in_valid = iv_v;
    bus.quo      = q_v;
    bus.den      = d_v;
    bus.rem      = r_v;
    @(posedge clk);
    if (rst_v) begin
      sb.delete();
    end else if (en_v) begin
      ecnt++;
      if (iv_v) begin
        e.num = int'(q_v) * int'(d_v) + int'(r_v);
        e.ovf = (e.num > 255);
        e.err = (d_v == 0) || (r_v >= d_v);
        e.due = ecnt + W;
        sb.push_back(e);
      end
    end
    #1;
    s_ov  = bus.out_valid;
    s_num = bus.num;
    s_ovf = bus.ovf;
    s_err = bus.rem_err;
    if (rst_v) begin
      chk("rst_valid", 32'(s_ov), 0);
      chk("rst_num", 32'(s_num), 0);
      chk("rst_ovf", 32'(s_ovf), 0);
      chk("rst_err", 32'(s_err), 0);
    end else if (!en_v) begin
      chk("hold_valid", 32'(s_ov), 32'(p_ov));
      chk("hold_num", 32'(s_num), 32'(p_num));
      chk("hold_ovf", 32'(s_ovf), 32'(p_ovf));
      chk("hold_err", 32'(s_err), 32'(p_err));
    end else if (sb.size() != 0 && sb[0].due == ecnt) begin
      e = sb.pop_front();
      chk("sb_valid", 32'(s_ov), 1);
      chk("sb_num", 32'(s_num), e.num);
      chk("sb_ovf", 32'(s_ovf), 32'(e.ovf));
      chk("sb_err", 32'(s_err), 32'(e.err));
    end else begin
      chk("idle_valid", 32'(s_ov), 0);
      chk("idle_num", 32'(s_num), 0);
      chk("idle_ovf", 32'(s_ovf), 0);
      chk("idle_err", 32'(s_err), 0);
    end
    p_ov  = s_ov;
    p_num = s_num;
    p_ovf = s_ovf;
    p_err = s_err;
    cyc++;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      default: v = W'($urandom_range(0, (1 << W) - 1));
    endcase
    return v;
  endfunction

  initial begin
    int          j;
    int          nops;
    int          guard;
    logic        rst_r, en_r, iv_r;
    logic [W-1:0] qr, dr, rr;

    tbl[0] = '{8'd2,   8'd2,   8'd1,   5,     1'b0, 1'b0};
    tbl[1] = '{8'd3,   8'd3,   8'd2,   11,    1'b0, 1'b0};
    tbl[2] = '{8'd2,   8'd77,  8'd36,  190,   1'b0, 1'b0};
    tbl[3] = '{8'd7,   8'd29,  8'd23,  226,   1'b0, 1'b0};
    tbl[4] = '{8'd255, 8'd255, 8'd255, 65280, 1'b1, 1'b1};
    tbl[5] = '{8'd0,   8'd0,   8'd0,   0,     1'b0, 1'b1};
    tbl[6] = '{8'd0,   8'd9,   8'd4,   4,     1'b0, 1'b0};

    p_ov = 1'b0; p_num = '0; p_ovf = 1'b0; p_err = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);

    // Round-trip and extreme vectors back-to-back: results on consecutive cycles after W.
    for (int c = 0; c < 7 + W + 1; c++) begin
      if (c < 7) cycle(1'b0, 1'b1, 1'b1, tbl[c].q, tbl[c].d, tbl[c].r);
      else       cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
      j = c - W;
      if (j >= 0 && j < 7) begin
        chk("vec_valid", 32'(s_ov), 1);
        chk("vec_num", 32'(s_num), tbl[j].num);
        chk("vec_ovf", 32'(s_ovf), 32'(tbl[j].ovf));
        chk("vec_err", 32'(s_err), 32'(tbl[j].err));
      end else begin
        chk("vec_gap_valid", 32'(s_ov), 0);
      end
    end

    // Bubbles: A, gap, gap, B gives out_valid 1,0,0,1.
    for (int c = 0; c <= W + 4; c++) begin
      if (c == 0)      cycle(1'b0, 1'b1, 1'b1, tbl[0].q, tbl[0].d, tbl[0].r);
      else if (c == 3) cycle(1'b0, 1'b1, 1'b1, tbl[2].q, tbl[2].d, tbl[2].r);
      else             cycle(1'b0, 1'b1, 1'b0, 8'd99, 8'd99, 8'd99);
      chk("bub_valid", 32'(s_ov), 32'((c == W) || (c == W + 3)));
      chk("bub_num", 32'(s_num), (c == W) ? tbl[0].num : (c == W + 3) ? tbl[2].num : 0);
    end

    // Stall: three ops, then en low for three edges with junk offered; results slip by 3.
    for (int c = 0; c <= W + 6; c++) begin
      if (c < 3)       cycle(1'b0, 1'b1, 1'b1, tbl[c].q, tbl[c].d, tbl[c].r);
      else if (c <= 5) cycle(1'b0, 1'b0, 1'b1, tbl[4].q, tbl[4].d, tbl[4].r);
      else             cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
      j = c - W - 3;
      if (j >= 0 && j < 3) begin
        chk("stall_valid", 32'(s_ov), 1);
        chk("stall_num", 32'(s_num), tbl[j].num);
      end else begin
        chk("stall_gap_valid", 32'(s_ov), 0);
      end
    end

    // Reset mid-flight flushes four ops; only the op issued after reset emerges.
    for (int c = 0; c <= W + 7; c++) begin
      if (c < 4)       cycle(1'b0, 1'b1, 1'b1, tbl[c].q, tbl[c].d, tbl[c].r);
      else if (c == 4) cycle(1'b1, 1'b1, 1'b1, tbl[4].q, tbl[4].d, tbl[4].r);
      else if (c == 5) cycle(1'b0, 1'b1, 1'b1, tbl[3].q, tbl[3].d, tbl[3].r);
      else             cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
      chk("rstop_valid", 32'(s_ov), 32'(c == 5 + W));
      chk("rstop_num", 32'(s_num), (c == 5 + W) ? 226 : 0);
    end

    // Random traffic with random enable, bubbles and rare resets.
    nops  = 0;
    guard = 0;
    while (nops < 10000 && guard < 60000) begin
      rst_r = ($urandom_range(0, 999) == 0);
      en_r  = ($urandom_range(0, 3) != 0);
      iv_r  = ($urandom_range(0, 3) != 0);
      qr    = rand_op();
      dr    = rand_op();
      rr    = ($urandom_range(0, 1) == 0 && dr != 0) ? W'($urandom_range(0, int'(dr) - 1)) : rand_op();
      if (!rst_r && en_r && iv_r) nops++;
      cycle(rst_r, en_r, iv_r, qr, dr, rr);
      guard++;
    end
    chk("rand_ops_issued", 32'(nops), 10000);

    for (int c = 0; c < W + 2; c++) cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
    chk("drain_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
